// File: rtl/tl_pkt_source.sv
// rtl/tl_pkt_source.sv - round-robin burst traffic source for the four TL input FIFOs
// Optional stall counter enabled by defining TL_SRC_STALL_CNT_EN.
module tl_pkt_source #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic [7:0]        seed,
    input  logic              almost_full0,
    input  logic              almost_full1,
    input  logic              almost_full2,
    input  logic              almost_full3,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    output logic [DATA_W-1:0] data_out3,
    output logic              push_out0,
    output logic              push_out1,
    output logic              push_out2,
    output logic              push_out3,
    output logic              done,
    input  logic              req,
    input  logic [1:0]        idx,
    output logic [CNT_W-1:0]  contador,
    output logic              valid,
    output logic [7:0]        stalls
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             remaining_q, remaining_d;
    logic [7:0]                   lfsr_q, lfsr_d;
    logic [1:0]                   dest_ptr_q, dest_ptr_d;
    logic [1:0]                   rr_ptr_q, rr_ptr_d;
    logic [3:0][CNT_W-1:0]        cnt_q, cnt_d;
    logic [3:0]                   push_q, push_d;
    logic [3:0][DATA_W-1:0]       data_q, data_d;
    logic                         done_q, done_d;
    logic [CNT_W-1:0]             contador_q, contador_d;
    logic                         valid_q, valid_d;

    logic [3:0] af;
    logic       found;
    logic [1:0] sel;
    logic [1:0] cand;

    assign af = {almost_full3, almost_full2, almost_full1, almost_full0};

    // Walk from rr_ptr upward; lower offsets are visited last so the first free channel wins.
    always_comb begin
        found = 1'b0;
        sel   = rr_ptr_q;
        cand  = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = rr_ptr_q + 2'(k);
            if (!af[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        lfsr_d      = lfsr_q;
        dest_ptr_d  = dest_ptr_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        push_d      = '0;
        data_d      = data_q;
        done_d      = 1'b0;
        valid_d     = req;
        contador_d  = req ? cnt_q[idx] : '0;

        case (state_q)
            S_IDLE: begin
                if (init) state_d = S_LOAD;
            end
            S_LOAD: begin
                remaining_d = burst_len;
                lfsr_d      = (seed == 8'h00) ? 8'h01 : seed;
                dest_ptr_d  = '0;
                rr_ptr_d    = '0;
                cnt_d       = '0;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (remaining_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (found) begin
                    push_d[sel] = 1'b1;
                    data_d[sel] = {dest_ptr_q, lfsr_q};
                    remaining_d = remaining_q - 1'b1;
                    dest_ptr_d  = dest_ptr_q + 2'd1;
                    rr_ptr_d    = sel + 2'd1;
                    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                    cnt_d[sel]  = cnt_q[sel] + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            lfsr_q      <= '0;
            dest_ptr_q  <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            push_q      <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            contador_q  <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            lfsr_q      <= lfsr_d;
            dest_ptr_q  <= dest_ptr_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            push_q      <= push_d;
            data_q      <= data_d;
            done_q      <= done_d;
            contador_q  <= contador_d;
            valid_q     <= valid_d;
        end
    end

`ifdef TL_SRC_STALL_CNT_EN
    logic [7:0] stalls_q, stalls_d;

    // Saturating count of SEND cycles with work pending but every FIFO blocked.
    always_comb begin
        stalls_d = stalls_q;
        if (state_q == S_LOAD) begin
            stalls_d = '0;
        end else if (state_q == S_SEND && remaining_q != '0 && !found && stalls_q != 8'hFF) begin
            stalls_d = stalls_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stalls_q <= '0;
        else        stalls_q <= stalls_d;
    end

    assign stalls = stalls_q;
`else
    assign stalls = '0;
`endif

    assign push_out0 = push_q[0];
    assign push_out1 = push_q[1];
    assign push_out2 = push_q[2];
    assign push_out3 = push_q[3];
    assign data_out0 = data_q[0];
    assign data_out1 = data_q[1];
    assign data_out2 = data_q[2];
    assign data_out3 = data_q[3];
    assign done      = done_q;
    assign contador  = contador_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_tl_pkt_source.sv
// tb/tb_tl_pkt_source.sv - directed self-checking bench for tl_pkt_source
module tb_tl_pkt_source;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       init = 1'b0;
    logic [4:0] burst_len = '0;
    logic [7:0] seed = '0;
    logic       almost_full0 = 1'b0, almost_full1 = 1'b0, almost_full2 = 1'b0, almost_full3 = 1'b0;
    logic [9:0] data_out0, data_out1, data_out2, data_out3;
    logic       push_out0, push_out1, push_out2, push_out3;
    logic       done;
    logic       req = 1'b0;
    logic [1:0] idx = '0;
    logic [4:0] contador;
    logic       valid;
    logic [7:0] stalls;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int multi_push = 0;
    int         log_ch[$];
    logic [9:0] log_data[$];
    int         log_cyc[$];

    tl_pkt_source dut (
        .clk(clk), .reset(reset), .init(init), .burst_len(burst_len), .seed(seed),
        .almost_full0(almost_full0), .almost_full1(almost_full1),
        .almost_full2(almost_full2), .almost_full3(almost_full3),
        .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3),
        .push_out0(push_out0), .push_out1(push_out1), .push_out2(push_out2), .push_out3(push_out3),
        .done(done), .req(req), .idx(idx), .contador(contador), .valid(valid), .stalls(stalls)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (push_out0) begin log_ch.push_back(0); log_data.push_back(data_out0); log_cyc.push_back(cyc); end
        if (push_out1) begin log_ch.push_back(1); log_data.push_back(data_out1); log_cyc.push_back(cyc); end
        if (push_out2) begin log_ch.push_back(2); log_data.push_back(data_out2); log_cyc.push_back(cyc); end
        if (push_out3) begin log_ch.push_back(3); log_data.push_back(data_out3); log_cyc.push_back(cyc); end
        if ($countones({push_out3, push_out2, push_out1, push_out0}) > 1) multi_push++;
        if (done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [4:0] len, input logic [7:0] s);
        burst_len = len;
        seed = s;
        init = 1'b1;
        step();
        init = 1'b0;
    endtask

    function automatic logic [63:0] all_outs();
        return {data_out0, data_out1, data_out2, data_out3, push_out0, push_out1, push_out2,
                push_out3, done, contador, valid, stalls};
    endfunction

    task automatic test_reset();
        #1;
        checks++;
        if (all_outs() !== 64'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        step(); step();
        reset = 1'b1;
        step();
        checks++;
        if (done !== 1'b0 || valid !== 1'b0 || {push_out0, push_out1, push_out2, push_out3} !== 4'b0) begin
            errors++; $display("FAIL reset_release_idle: done=%b valid=%b", done, valid);
        end
    endtask

    task automatic test_basic();
        int exp_ch[5]   = '{0, 1, 2, 3, 0};
        int exp_dat[5]  = '{10'h001, 10'h102, 10'h204, 10'h308, 10'h011};
        int exp_cnt[4]  = '{2, 1, 1, 1};
        int n0 = log_ch.size();
        int k = 0;
        int d0 = done_cnt;
        start_burst(5'd5, 8'h01);
        while (done !== 1'b1 && k < 30) begin step(); k++; end
        checks++;
        if (k != 7) begin errors++; $display("FAIL basic_done_latency: got %0d expected 7", k); end
        checks++;
        if (log_ch.size() - n0 != 5) begin
            errors++; $display("FAIL basic_push_count: got %0d expected 5", log_ch.size() - n0);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (log_ch[n0+i] != exp_ch[i] || log_data[n0+i] !== 10'(exp_dat[i]) ||
                    log_cyc[n0+i] != log_cyc[n0] + i) begin
                    errors++;
                    $display("FAIL basic_word%0d: ch=%0d data=%h cyc+%0d expected ch=%0d data=%h cyc+%0d",
                             i, log_ch[n0+i], log_data[n0+i], log_cyc[n0+i] - log_cyc[n0],
                             exp_ch[i], exp_dat[i], i);
                end
            end
        end
        step();
        checks++;
        if (done !== 1'b0 || done_cnt - d0 != 1) begin
            errors++; $display("FAIL basic_done_pulse: done=%b pulses=%0d expected 0/1", done, done_cnt - d0);
        end
        for (int i = 0; i < 4; i++) begin
            req = 1'b1; idx = 2'(i);
            step();
            checks++;
            if (valid !== 1'b1 || contador !== 5'(exp_cnt[i])) begin
                errors++; $display("FAIL basic_cnt%0d: valid=%b cnt=%0d expected 1/%0d", i, valid, contador, exp_cnt[i]);
            end
        end
        req = 1'b0;
        step();
        checks++;
        if (valid !== 1'b0 || contador !== 5'd0) begin
            errors++; $display("FAIL basic_read_idle: valid=%b cnt=%0d expected 0/0", valid, contador);
        end
    endtask

    task automatic test_backpressure();
        int exp_ch[4]  = '{0, 2, 3, 0};
        int exp_dat[4] = '{10'h001, 10'h102, 10'h204, 10'h308};
        int exp_cnt[4] = '{2, 0, 1, 1};
        int n0 = log_ch.size();
        int k = 0;
        almost_full1 = 1'b1;
        start_burst(5'd4, 8'h01);
        while (done !== 1'b1 && k < 30) begin step(); k++; end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL bp_done_timeout: done=%b expected 1", done); end
        checks++;
        if (log_ch.size() - n0 != 4) begin
            errors++; $display("FAIL bp_push_count: got %0d expected 4", log_ch.size() - n0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_ch[n0+i] != exp_ch[i] || log_data[n0+i] !== 10'(exp_dat[i])) begin
                    errors++;
                    $display("FAIL bp_word%0d: ch=%0d data=%h expected ch=%0d data=%h",
                             i, log_ch[n0+i], log_data[n0+i], exp_ch[i], exp_dat[i]);
                end
            end
        end
        almost_full1 = 1'b0;
        step();
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL bp_valid_before_req: got %b expected 0", valid); end
        for (int i = 0; i < 4; i++) begin
            req = 1'b1; idx = 2'(i);
            step();
            checks++;
            if (valid !== 1'b1 || contador !== 5'(exp_cnt[i])) begin
                errors++; $display("FAIL bp_cnt%0d: valid=%b cnt=%0d expected 1/%0d", i, valid, contador, exp_cnt[i]);
            end
        end
        req = 1'b0;
        step();
    endtask

    task automatic test_stall();
        int exp_ch[6]  = '{0, 1, 2, 3, 0, 1};
        int exp_dat[6] = '{10'h001, 10'h102, 10'h204, 10'h308, 10'h011, 10'h123};
        int n0 = log_ch.size();
        int k = 0;
        logic [7:0] exp_stalls;
`ifdef TL_SRC_STALL_CNT_EN
        exp_stalls = 8'd6;
`else
        exp_stalls = 8'd0;
`endif
        start_burst(5'd6, 8'h01);
        step(); step(); step();
        {almost_full0, almost_full1, almost_full2, almost_full3} = 4'hF;
        repeat (6) step();
        checks++;
        if (log_ch.size() - n0 != 2 || {push_out0, push_out1, push_out2, push_out3} !== 4'b0) begin
            errors++; $display("FAIL stall_window_pushes: got %0d expected 2", log_ch.size() - n0);
        end
        {almost_full0, almost_full1, almost_full2, almost_full3} = 4'h0;
        while (done !== 1'b1 && k < 30) begin step(); k++; end
        checks++;
        if (stalls !== exp_stalls) begin
            errors++; $display("FAIL stall_count: got %0d expected %0d", stalls, exp_stalls);
        end
        checks++;
        if (log_ch.size() - n0 != 6) begin
            errors++; $display("FAIL stall_push_count: got %0d expected 6", log_ch.size() - n0);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (log_ch[n0+i] != exp_ch[i] || log_data[n0+i] !== 10'(exp_dat[i])) begin
                    errors++;
                    $display("FAIL stall_word%0d: ch=%0d data=%h expected ch=%0d data=%h",
                             i, log_ch[n0+i], log_data[n0+i], exp_ch[i], exp_dat[i]);
                end
            end
            checks++;
            if (log_cyc[n0+2] - log_cyc[n0+1] != 7) begin
                errors++; $display("FAIL stall_resume_gap: got %0d expected 7", log_cyc[n0+2] - log_cyc[n0+1]);
            end
        end
        step();
    endtask

    task automatic test_zero_len();
        int n0 = log_ch.size();
        start_burst(5'd0, 8'h00);
        step();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL zero_done_early: got %b expected 0", done); end
        step();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL zero_done_pulse: got %b expected 1", done); end
        step();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL zero_done_late: got %b expected 0", done); end
        step();
        checks++;
        if (log_ch.size() != n0) begin
            errors++; $display("FAIL zero_no_push: got %0d expected 0", log_ch.size() - n0);
        end
    endtask

    task automatic test_reset_mid();
        int n1;
        int d0 = done_cnt;
        start_burst(5'd10, 8'h01);
        step(); step(); step(); step();
        checks++;
        if (push_out2 !== 1'b1 || data_out2 !== 10'h204) begin
            errors++; $display("FAIL rst_third_word: push2=%b data=%h expected 1/204", push_out2, data_out2);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 64'd0) begin
            errors++; $display("FAIL rst_mid_outputs: got %h expected 0", all_outs());
        end
        n1 = log_ch.size();
        repeat (3) step();
        reset = 1'b1;
        repeat (15) step();
        checks++;
        if (log_ch.size() != n1 || done_cnt != d0) begin
            errors++; $display("FAIL rst_no_more_pushes: got %0d pushes expected 0", log_ch.size() - n1);
        end
        for (int i = 0; i < 4; i++) begin
            req = 1'b1; idx = 2'(i);
            step();
            checks++;
            if (valid !== 1'b1 || contador !== 5'd0) begin
                errors++; $display("FAIL rst_cnt%0d: valid=%b cnt=%0d expected 1/0", i, valid, contador);
            end
        end
        req = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int n0 = log_ch.size();
        int d0 = done_cnt;
        int seen = 0;
        int k = 0;
        burst_len = 5'd31;
        seed = 8'h01;
        init = 1'b1;
        while (seen < 2 && k < 200) begin
            step(); k++;
            if (done === 1'b1) begin
                seen++;
                if (seen == 2) init = 1'b0;
                req = 1'b1; idx = 2'd0;
                step(); k++;
                req = 1'b0;
                checks++;
                if (valid !== 1'b1 || contador !== 5'd8) begin
                    errors++; $display("FAIL b2b_cnt0_burst%0d: valid=%b cnt=%0d expected 1/8", seen, valid, contador);
                end
            end
        end
        init = 1'b0;
        repeat (5) step();
        checks++;
        if (done_cnt - d0 != 2) begin
            errors++; $display("FAIL b2b_done_pulses: got %0d expected 2", done_cnt - d0);
        end
        checks++;
        if (log_ch.size() - n0 != 62) begin
            errors++; $display("FAIL b2b_push_count: got %0d expected 62", log_ch.size() - n0);
        end else begin
            checks++;
            if (log_cyc[n0+31] - log_cyc[n0+30] != 5 || log_ch[n0+31] != 0 || log_data[n0+31] !== 10'h001) begin
                errors++;
                $display("FAIL b2b_restart: gap=%0d ch=%0d data=%h expected 5/0/001",
                         log_cyc[n0+31] - log_cyc[n0+30], log_ch[n0+31], log_data[n0+31]);
            end
        end
        checks++;
        if (multi_push != 0) begin
            errors++; $display("FAIL one_push_per_cycle: got %0d expected 0", multi_push);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stall();
        test_zero_len();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
